// File: rtl/lfsr_decrypt_if.sv
// -----------------------------------------------------------------------------
// lfsr_decrypt_if
// Shared dat_mem port bundle between the LFSR decryptor and the data memory.
//   raddr    : read address (memory answers combinationally on data_out)
//   data_out : read data returned by the memory
//   write_en : write strobe, memory writes on the rising clock edge
//   waddr    : write address
//   data_in  : write data
// master = decryptor side, slave = memory side.
// -----------------------------------------------------------------------------
interface lfsr_decrypt_if;
  logic [7:0] raddr;
  logic [7:0] data_out;
  logic       write_en;
  logic [7:0] waddr;
  logic [7:0] data_in;

  modport master (
    output raddr,
    output write_en,
    output waddr,
    output data_in,
    input  data_out
  );

  modport slave (
    input  raddr,
    input  write_en,
    input  waddr,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/lfsr_decrypt.sv
// -----------------------------------------------------------------------------
// lfsr_decrypt
// Decryptor for the 6-bit LFSR stream cipher. Reads CT_LEN ciphertext bytes
// starting at CT_BASE, recovers the LFSR seed from the known preamble byte,
// searches six candidate feedback tap patterns for the one that reproduces
// PRE_MIN preamble bytes, then decrypts, strips the leading preamble and
// writes the plaintext to PT_BASE onward.
// Ports:
//   clk      : clock, all state on posedge
//   init_n   : asynchronous active-low reset
//   start    : one-cycle start pulse, honoured only in IDLE/DONE/FAIL
//   mem      : dat_mem bundle (raddr/data_out/write_en/waddr/data_in)
//   taps_sel : tap pattern found (valid when done)
//   pre_len  : number of preamble bytes stripped (valid when done)
//   busy     : high while seeding, searching taps or decoding
//   done     : high in DONE and FAIL until the next accepted start
//   err      : high in FAIL (no candidate matched)
// -----------------------------------------------------------------------------
module lfsr_decrypt #(
  parameter logic [7:0]  CT_BASE  = 8'd64,
  parameter int          CT_LEN   = 64,
  parameter logic [7:0]  PT_BASE  = 8'd0,
  parameter logic [7:0]  PRE_CHAR = 8'h5F,
  parameter int          PRE_MIN  = 7,
  // Six packed 6-bit candidates, index 0 in [5:0]: 21,2D,30,33,36,39
  parameter logic [35:0] TAPS     = 36'hE76CF0B61
) (
  input  logic                  clk,
  input  logic                  init_n,
  input  logic                  start,
  lfsr_decrypt_if.master        mem,
  output logic [5:0]            taps_sel,
  output logic [7:0]            pre_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SEED   = 3'd1;
  localparam logic [2:0] TRY    = 3'd2;
  localparam logic [2:0] DECODE = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam logic [2:0] FAIL   = 3'd5;

  localparam logic [2:0] K_LAST   = 3'd5;
  localparam logic [7:0] PRE_LAST = 8'(PRE_MIN - 1);
  localparam logic [7:0] CT_LAST  = 8'(CT_LEN - 1);

  function automatic logic [5:0] lfsr_step(input logic [5:0] s, input logic [5:0] tap);
    return {s[4:0], ^(s & tap)};
  endfunction

  function automatic logic [5:0] tap_at(input logic [2:0] k);
    return 6'(TAPS >> (6 * int'(k)));
  endfunction

  logic [2:0] state_q, state_d;
  logic [5:0] seed_q, seed_d;
  logic [5:0] s_q, s_d;
  logic [2:0] k_q, k_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic       pre_q, pre_d;
  logic [5:0] taps_q, taps_d;
  logic [7:0] pre_len_q, pre_len_d;

  logic [5:0] cand;
  logic [5:0] nxt;
  logic [5:0] seed_rd;
  logic [7:0] plain;

  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    s_d       = s_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    i_d       = i_q;
    j_d       = j_q;
    pre_d     = pre_q;
    taps_d    = taps_q;
    pre_len_d = pre_len_q;

    mem.raddr    = CT_BASE;
    mem.write_en = 1'b0;
    mem.waddr    = CT_BASE;
    mem.data_in  = 8'h00;

    cand    = tap_at(k_q);
    nxt     = lfsr_step(s_q, cand);
    seed_rd = mem.data_out[5:0] ^ PRE_CHAR[5:0];
    plain   = mem.data_out ^ {2'b00, s_q};

    case (state_q)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_d   = SEED;
          pre_len_d = 8'd0;
        end
      end

      // Byte 0 is a preamble byte, so it directly exposes the seed.
      SEED: begin
        seed_d  = seed_rd;
        s_d     = seed_rd;
        k_d     = 3'd0;
        cnt_d   = 8'd1;
        state_d = TRY;
      end

      // Walk candidate k forward; the first mismatch moves to the next candidate.
      TRY: begin
        mem.raddr = CT_BASE + cnt_q;
        if (mem.data_out == ({2'b00, nxt} ^ PRE_CHAR)) begin
          if (cnt_q == PRE_LAST) begin
            taps_d  = cand;
            s_d     = seed_q;
            i_d     = 8'd0;
            j_d     = 8'd0;
            pre_d   = 1'b1;
            state_d = DECODE;
          end else begin
            s_d   = nxt;
            cnt_d = cnt_q + 8'd1;
          end
        end else if (k_q != K_LAST) begin
          k_d   = k_q + 3'd1;
          s_d   = seed_q;
          cnt_d = 8'd1;
        end else begin
          state_d = FAIL;
        end
      end

      // Only the leading run of preamble bytes is dropped; once a real byte
      // has been written, later '_' characters are ordinary plaintext.
      DECODE: begin
        mem.raddr = CT_BASE + i_q;
        if (pre_q && (plain == PRE_CHAR)) begin
          pre_len_d = pre_len_q + 8'd1;
        end else begin
          mem.write_en = 1'b1;
          mem.waddr    = PT_BASE + j_q;
          mem.data_in  = plain;
          j_d          = j_q + 8'd1;
          pre_d        = 1'b0;
        end
        s_d = lfsr_step(s_q, taps_q);
        i_d = i_q + 8'd1;
        if (i_q == CT_LAST) state_d = DONE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q   <= IDLE;
      seed_q    <= 6'd0;
      s_q       <= 6'd0;
      k_q       <= 3'd0;
      cnt_q     <= 8'd0;
      i_q       <= 8'd0;
      j_q       <= 8'd0;
      pre_q     <= 1'b0;
      taps_q    <= 6'd0;
      pre_len_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      s_q       <= s_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      i_q       <= i_d;
      j_q       <= j_d;
      pre_q     <= pre_d;
      taps_q    <= taps_d;
      pre_len_q <= pre_len_d;
    end
  end

  assign taps_sel = taps_q;
  assign pre_len  = pre_len_q;
  assign busy     = (state_q == SEED) || (state_q == TRY) || (state_q == DECODE);
  assign done     = (state_q == DONE) || (state_q == FAIL);
  assign err      = (state_q == FAIL);

endmodule

// File: tb/tb_lfsr_decrypt.sv
module tb_lfsr_decrypt;

  logic       clk;
  logic       init_n;
  logic       start;
  logic [5:0] taps_sel;
  logic [7:0] pre_len;
  logic       busy;
  logic       done;
  logic       err;

  lfsr_decrypt_if bus();

  lfsr_decrypt dut (
    .clk      (clk),
    .init_n   (init_n),
    .start    (start),
    .mem      (bus),
    .taps_sel (taps_sel),
    .pre_len  (pre_len),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ciphertext region (read) and plaintext region (written by the DUT)
  logic [7:0] ct_mem [0:255];
  logic [7:0] pt_mem [0:63];
  logic [7:0] pt     [0:63];
  logic       clr;
  int         wr_cnt = 0;

  assign bus.data_out = ct_mem[bus.raddr];

  always @(posedge clk) begin
    if (clr) begin
      for (int a = 0; a < 64; a++) pt_mem[a] <= 8'hEE;
    end else if (bus.write_en) begin
      pt_mem[bus.waddr[5:0]] <= bus.data_in;
    end
    if (bus.write_en) wr_cnt <= wr_cnt + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [5:0] enc_step(input logic [5:0] s, input logic [5:0] tap);
    return {s[4:0], ^(s & tap)};
  endfunction

  // Encryptor model: npre preamble bytes, message, '.' padding
  task automatic build(input logic [5:0] seed, input logic [5:0] tap, input int npre, input string msg);
    logic [5:0] s;
    s = seed;
    for (int i = 0; i < 64; i++) begin
      if (i < npre) pt[i] = 8'h5F;
      else if (i - npre < msg.len()) pt[i] = msg[i - npre];
      else pt[i] = 8'h2E;
      ct_mem[64 + i] = pt[i] ^ {2'b00, s};
      s = enc_step(s, tap);
    end
  endtask

  task automatic clear_pt();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  // Starts a run and counts edges after the start-sampling edge until done.
  task automatic run_dec(input string t, input int pulse_at, output int edges, output int writes);
    int w0;
    w0 = wr_cnt;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    edges = 0;
    while (!done && edges < 400) begin
      @(posedge clk); #1;
      start = 1'b0;
      edges++;
      if (edges == pulse_at) begin
        check({t, " busy at extra start"}, busy, 1'b1);
        start = 1'b1;
      end
    end
    check({t, " done reached"}, done, 1'b1);
    writes = wr_cnt - w0;
  endtask

  task automatic check_pt(input string t, input int npre);
    for (int j = 0; j < 64 - npre; j++)
      check($sformatf("%s pt[%0d]", t, j), pt_mem[j], pt[npre + j]);
  endtask

  localparam string MSG1 = "The quick brown fox jumps over lazy dogs";

  int edges;
  int writes;

  initial begin
    init_n = 1'b0;
    start  = 1'b0;
    clr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst err", err, 1'b0);
    check("rst write_en", bus.write_en, 1'b0);
    check("rst taps_sel", taps_sel, 6'h00);
    check("rst pre_len", pre_len, 8'd0);
    check("rst raddr", bus.raddr, 8'd64);
    check("rst waddr", bus.waddr, 8'd64);
    check("rst data_in", bus.data_in, 8'h00);
    @(negedge clk); init_n = 1'b1;

    // 1: correct tap at index 0
    build(6'h01, 6'h21, 10, MSG1);
    clear_pt();
    run_dec("t1", 0, edges, writes);
    check("t1 latency", edges, 71);
    check("t1 taps_sel", taps_sel, 6'h21);
    check("t1 pre_len", pre_len, 8'd10);
    check("t1 err", err, 1'b0);
    check("t1 busy", busy, 1'b0);
    check("t1 writes", writes, 54);
    check("t1 raddr idle", bus.raddr, 8'd64);
    check_pt("t1", 10);
    check("t1 untouched", pt_mem[54], 8'hEE);

    // 2: tap at index 5; five rejections cost 4+3+1+2+1 TRY cycles
    build(6'h01, 6'h39, 7, "Hello, LFSR world! 0123456789");
    clear_pt();
    run_dec("t2", 0, edges, writes);
    check("t2 latency", edges, 82);
    check("t2 taps_sel", taps_sel, 6'h39);
    check("t2 err", err, 1'b0);
    check("t2 pre_len", pre_len, 8'd7);
    check("t2 writes", writes, 57);
    check_pt("t2", 7);

    // 3: garbage ciphertext, byte 1 top bits never 01 -> every candidate fails at cnt=1
    for (int i = 0; i < 64; i++) ct_mem[64 + i] = 8'hC3 ^ 8'(i);
    clear_pt();
    run_dec("t3", 0, edges, writes);
    check("t3 latency", edges, 7);
    check("t3 err", err, 1'b1);
    check("t3 done", done, 1'b1);
    check("t3 writes", writes, 0);
    check("t3 mem0", pt_mem[0], 8'hEE);

    // 4: interior '_' characters are plaintext
    build(6'h2A, 6'h21, 8, "a_b__c_");
    clear_pt();
    run_dec("t4", 0, edges, writes);
    check("t4 pre_len", pre_len, 8'd8);
    check("t4 writes", writes, 56);
    check("t4 interior underscore", pt_mem[1], 8'h5F);
    check("t4 byte0", pt_mem[0], 8'h61);
    check_pt("t4", 8);

    // 5: all-preamble ciphertext, extra start while busy is ignored
    build(6'h15, 6'h21, 64, "");
    clear_pt();
    run_dec("t5", 30, edges, writes);
    check("t5 latency", edges, 71);
    check("t5 pre_len", pre_len, 8'd64);
    check("t5 writes", writes, 0);
    check("t5 err", err, 1'b0);
    check("t5 done", done, 1'b1);
    check("t5 mem0", pt_mem[0], 8'hEE);

    // 6: reset during DECODE i=20
    build(6'h01, 6'h21, 10, MSG1);
    clear_pt();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (27) @(posedge clk);
    #1;
    check("t6 write_en pre-rst", bus.write_en, 1'b1);
    check("t6 waddr pre-rst", bus.waddr, 8'd10);
    init_n = 1'b0;
    #1;
    check("t6 write_en rst", bus.write_en, 1'b0);
    check("t6 busy rst", busy, 1'b0);
    check("t6 done rst", done, 1'b0);
    check("t6 raddr rst", bus.raddr, 8'd64);
    check("t6 partial pt[9]", pt_mem[9], pt[19]);
    check("t6 unwritten pt[10]", pt_mem[10], 8'hEE);
    @(negedge clk); init_n = 1'b1;
    clear_pt();
    run_dec("t6r", 0, edges, writes);
    check("t6r latency", edges, 71);
    check("t6r taps_sel", taps_sel, 6'h21);
    check("t6r pre_len", pre_len, 8'd10);
    check("t6r writes", writes, 54);
    check_pt("t6r", 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
